stream_sched: RTL and testbench

Stateful message scheduler between the transmit-stream producers (command responses, sample streams, and future sources) and the tx framer. Arbitrates among four message sources, then locks the grant to one source for a whole message. Locked words pass straight through to the framer's avail/pull handshake. Source 0 (responses) has strict priority, bounded by an optional anti-starvation limit. Sources 1–3 share round-robin.

---
 rtl/stream_sched.sv | 161 ++++++++++++++++
 tb/tb_stream_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sched.sv
// stream_sched: message scheduler between four transmit-stream sources and
// the tx framer. In IDLE it arbitrates among the sources. Source 0 has
// strict priority, and sources 1-3 share round-robin. It then locks the
// grant to the winner for the whole message and passes that source's
// words straight through to the framer handshake.
//
// Optional feature: define STREAM_SCHED_STARVE_EN to enable the
// anti-starvation counter. After STARVE_LIMIT consecutive source-0 grants
// taken while any of sources 1-3 waits, one of sources 1-3 is served.
// Without the macro, source 0 always wins when it is available.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   src_data[128]     word from source n on bits [32n+31:32n]
//   src_count[32]     message length of source n on bits [8n+7:8n] (read at grant)
//   src_avail[4]      source n has a word ready
//   src_pull[4]       word from source n consumed this cycle
//   strm_data[32]     current word of the granted message (0 outside SEND)
//   strm_count[8]     latched length of the granted message
//   strm_id[4]        latched id of the granted source
//   strm_avail        granted word valid toward the framer
//   strm_pull         framer consumes strm_data this cycle
//   busy              a message is granted
module stream_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] src_data,
  input  logic [31:0]  src_count,
  input  logic [3:0]   src_avail,
  output logic [3:0]   src_pull,
  output logic [31:0]  strm_data,
  output logic [7:0]   strm_count,
  output logic [3:0]   strm_id,
  output logic         strm_avail,
  input  logic         strm_pull,
  output logic         busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  id_q;      // granted source
  logic [1:0]  rr_q;      // last source 1-3 served; only ever 1..3
  logic [7:0]  cnt_q;     // latched message length
  logic [7:0]  rem_q;     // words still to pull
  logic [1:0]  win;
  logic [7:0]  win_cnt;
  logic        s0_ok;     // source 0 may take priority this grant
  logic        others;
  logic        grant;
  logic        fire;
  logic        last;

  assign others  = |src_avail[3:1];
  assign grant   = (state_q == IDLE) && (src_avail != 4'b0000);
  assign win_cnt = src_count[{win, 3'b000} +: 8];
  // Computed from state directly rather than from the strm_avail output,
  // so the FSM process has no path back through its own outputs.
  assign fire    = (state_q == SEND) && src_avail[id_q] && strm_pull;
  assign last    = fire && (rem_q == 8'd1);

  assign strm_id    = {2'b00, id_q};
  assign strm_count = cnt_q;

`ifdef STREAM_SCHED_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q;

  assign s0_ok = (starve_q < LIMIT);

  // Counts source-0 grants taken while one of sources 1-3 waits. Any other
  // grant, including a zero-length grant, resets the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (grant) begin
      if (win == 2'd0 && others) begin
        if (starve_q != 4'hF) starve_q <= starve_q + 4'd1;
      end else begin
        starve_q <= 4'd0;
      end
    end
  end
`else
  // Without the counter, source 0 always wins and the limit has no effect.
  logic unused_limit;
  assign unused_limit = ^4'(STARVE_LIMIT);
  assign s0_ok = 1'b1;
`endif

  // Winner: source 0 when allowed, otherwise the first requester among 1-3
  // after rr_q (wrapping 3 -> 1). If none of 1-3 requests, source 0 wins.
  always_comb begin
    win = 2'd0;
    if (!(src_avail[0] && s0_ok)) begin
      case (rr_q)
        2'd1: begin
          if      (src_avail[2]) win = 2'd2;
          else if (src_avail[3]) win = 2'd3;
          else if (src_avail[1]) win = 2'd1;
        end
        2'd2: begin
          if      (src_avail[3]) win = 2'd3;
          else if (src_avail[1]) win = 2'd1;
          else if (src_avail[2]) win = 2'd2;
        end
        default: begin
          if      (src_avail[1]) win = 2'd1;
          else if (src_avail[2]) win = 2'd2;
          else if (src_avail[3]) win = 2'd3;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    strm_avail = 1'b0;
    strm_data  = 32'd0;
    src_pull   = 4'd0;
    case (state_q)
      IDLE: begin
        // A zero-length grant updates arbitration state but is not entered.
        if (grant && win_cnt != 8'd0) state_d = SEND;
      end
      SEND: begin
        busy       = 1'b1;
        strm_avail = src_avail[id_q];
        strm_data  = src_data[{id_q, 5'b00000} +: 32];
        if (fire) src_pull = 4'b0001 << id_q;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q  <= 2'd0;
      cnt_q <= 8'd0;
      rem_q <= 8'd0;
      rr_q  <= 2'd3;
    end else if (grant) begin
      id_q  <= win;
      cnt_q <= win_cnt;
      rem_q <= win_cnt;
      if (win != 2'd0) rr_q <= win;
    end else if (fire) begin
      rem_q <= rem_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_sched.sv
module tb_stream_sched;
  localparam int LIMIT = 2;
`ifdef STREAM_SCHED_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src_data;
  logic [31:0]  src_count;
  logic [3:0]   src_avail;
  logic [3:0]   src_pull;
  logic [31:0]  strm_data;
  logic [7:0]   strm_count;
  logic [3:0]   strm_id;
  logic         strm_avail;
  logic         strm_pull;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // reference model state (transaction-level view of the scheduler)
  bit       m_busy;
  int       m_id, m_cnt, m_rem, m_starve, m_rr;

  stream_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_count(src_count),
    .src_avail(src_avail), .src_pull(src_pull), .strm_data(strm_data),
    .strm_count(strm_count), .strm_id(strm_id), .strm_avail(strm_avail),
    .strm_pull(strm_pull), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] a);
    int c;
    if (a[0] && (!STARVE_ON || m_starve < LIMIT)) return 0;
    for (int k = 1; k <= 3; k++) begin
      c = ((m_rr - 1 + k) % 3) + 1;
      if (a[c]) return c;
    end
    return 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; src_avail = 4'hF; strm_pull = 1'b1;
    src_count = 32'h01010101; src_data = {4{32'hDEADBEEF}};
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({busy, strm_avail, src_pull, strm_data, strm_id, strm_count} !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b av=%b pull=%b data=%h id=%0d cnt=%0d want all 0",
               busy, strm_avail, src_pull, strm_data, strm_id, strm_count);
    end
    rst = 1'b0; src_avail = 4'h0; strm_pull = 1'b0;
  endtask

  task automatic test_single();
    int pulls = 0;
    @(negedge clk);
    src_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    src_count = 32'h0000_0300; src_avail = 4'b0010; strm_pull = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_cycle0_busy got %b want 0", busy); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1 || strm_id !== 4'd1 || strm_count !== 8'd3 || strm_data !== 32'h1111_0001) begin
          errors++;
          $display("FAIL single_grant got busy=%b id=%0d cnt=%0d data=%h want 1 1 3 11110001",
                   busy, strm_id, strm_count, strm_data);
        end
      end
      if (busy) begin
        if (src_pull === 4'b0010) pulls++;
      end else begin
        src_avail = 4'b0000;
        break;
      end
    end
    checks++;
    if (pulls != 3 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulls got %0d busy=%b want 3 busy=0", pulls, busy);
    end
  endtask

  task automatic test_priority();
    logic       eb [1:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ep [1:6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    @(negedge clk);
    src_count = 32'h0002_0002; src_avail = 4'b0101; strm_pull = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) src_avail = 4'b0100;  // source 0 finished; let source 2 through
      if (c == 6) src_avail = 4'b0000;
      #1;
      checks++;
      if (busy !== eb[c] || src_pull !== ep[c]) begin
        errors++;
        $display("FAIL priority_c%0d got busy=%b pull=%b want busy=%b pull=%b", c, busy, src_pull, eb[c], ep[c]);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (strm_id !== ((c == 1) ? 4'd0 : 4'd2)) begin
          errors++; $display("FAIL priority_id_c%0d got %0d", c, strm_id);
        end
      end
    end
  endtask

  // Drive a constant avail pattern with one-word messages and record the
  // first six granted ids.
  task automatic collect_grants(input logic [3:0] a, output int ids [6]);
    int  n = 0;
    bit  prev = 1'b0;
    for (int k = 0; k < 6; k++) ids[k] = -1;
    @(negedge clk);
    src_count = 32'h0101_0101; src_avail = a; strm_pull = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (busy && !prev && n < 6) begin ids[n] = int'(strm_id); n++; end
      prev = busy;
      if (n == 6 && !busy) break;
    end
    src_avail = 4'b0000;
  endtask

  task automatic test_starve();
    int ids [6];
    int exp [6];
    exp = STARVE_ON ? '{0, 0, 3, 0, 0, 3} : '{0, 0, 0, 0, 0, 0};
    collect_grants(4'b1001, ids);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ids[k] != exp[k]) begin
        errors++; $display("FAIL starve_grant%0d got %0d want %0d", k, ids[k], exp[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int ids [6];
    int exp [6] = '{1, 2, 3, 1, 2, 3};
    collect_grants(4'b1110, ids);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ids[k] != exp[k]) begin
        errors++; $display("FAIL rr_grant%0d got %0d want %0d", k, ids[k], exp[k]);
      end
    end
  endtask

  task automatic test_stall_zero();
    logic [3:0] ep;
    logic       eb;
    @(negedge clk);
    src_count = 32'h0000_0400; strm_pull = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clk);
      src_avail = ((c >= 3 && c <= 6) || c >= 9) ? 4'b0000 : 4'b0010;
      #1;
      eb = (c >= 1 && c <= 8);
      ep = (c == 1 || c == 2 || c == 7 || c == 8) ? 4'b0010 : 4'b0000;
      checks++;
      if (busy !== eb || src_pull !== ep || (eb && strm_id !== 4'd1)) begin
        errors++;
        $display("FAIL stall_c%0d got busy=%b pull=%b id=%0d want busy=%b pull=%b id=1",
                 c, busy, src_pull, strm_id, eb, ep);
      end
    end
    // zero-length message from source 2: never entered, never pulled
    @(negedge clk);
    src_count = 32'h0000_0000; src_avail = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || src_pull !== 4'b0000) begin
        errors++; $display("FAIL zero_count_c%0d got busy=%b pull=%b want 0 0000", c, busy, src_pull);
      end
    end
    src_avail = 4'b0000;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    src_count = 32'h0500_0000; src_avail = 4'b1000; strm_pull = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (src_pull !== 4'b1000) begin
        errors++; $display("FAIL rstmid_pull_c%0d got %b want 1000", c, src_pull);
      end
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({busy, strm_avail, src_pull, strm_data, strm_id, strm_count} !== 49'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got busy=%b av=%b pull=%b data=%h id=%0d cnt=%0d want all 0",
               busy, strm_avail, src_pull, strm_data, strm_id, strm_count);
    end
    src_avail = 4'b0000; rst = 1'b0;
  endtask

  task automatic test_random();
    logic        e_av;
    logic [3:0]  e_pull;
    logic [31:0] e_data;
    int          w;
    @(negedge clk); rst = 1'b1; src_avail = 4'b0000;
    @(negedge clk); rst = 1'b0;
    m_busy = 1'b0; m_id = 0; m_cnt = 0; m_rem = 0; m_starve = 0; m_rr = 3;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) @(negedge clk);
      src_avail = 4'($urandom_range(0, 15));
      src_data  = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < 4; s++) src_count[s*8 +: 8] = 8'($urandom_range(0, 3));
      strm_pull = ($urandom_range(0, 3) != 0);
      #1;
      e_av   = m_busy && src_avail[m_id];
      e_pull = (e_av && strm_pull) ? 4'(1 << m_id) : 4'b0000;
      e_data = m_busy ? src_data[m_id*32 +: 32] : 32'd0;
      checks++;
      if (busy !== m_busy || strm_avail !== e_av) begin
        errors++; $display("FAIL rand_state cyc=%0d got busy=%b av=%b want %b %b", cyc, busy, strm_avail, m_busy, e_av);
      end
      checks++;
      if (src_pull !== e_pull || strm_data !== e_data) begin
        errors++; $display("FAIL rand_data cyc=%0d got pull=%b data=%h want %b %h", cyc, src_pull, strm_data, e_pull, e_data);
      end
      if (m_busy) begin
        checks++;
        if (strm_id !== 4'(m_id) || strm_count !== 8'(m_cnt)) begin
          errors++; $display("FAIL rand_grant cyc=%0d got id=%0d cnt=%0d want %0d %0d", cyc, strm_id, strm_count, m_id, m_cnt);
        end
      end
      @(posedge clk);
      if (!m_busy) begin
        if (src_avail != 4'b0000) begin
          w = pick(src_avail);
          m_id = w; m_cnt = int'(src_count[w*8 +: 8]);
          if (STARVE_ON) m_starve = (w == 0 && src_avail[3:1] != 3'b000) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
          if (w != 0) m_rr = w;
          if (m_cnt != 0) begin m_busy = 1'b1; m_rem = m_cnt; end
        end
      end else if (strm_pull && src_avail[m_id]) begin
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; src_avail = 4'b0000; strm_pull = 1'b0;
    src_count = 32'd0; src_data = '0;
    test_reset();
    test_single();
    test_priority();
    test_starve();
    test_stall_zero();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
